// File: rtl/code_conv_pkg.sv
// Shared definitions for the code-conversion arbiter: mode encodings and FSM states.
package code_conv_pkg;

    localparam logic [1:0] MODE_B2G     = 2'd0;
    localparam logic [1:0] MODE_G2B     = 2'd1;
    localparam logic [1:0] MODE_BCD2XS3 = 2'd2;
    localparam logic [1:0] MODE_XS32BCD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/code_conv_core.sv
// Combinational 4-bit code converter: binary/Gray in both directions and BCD/excess-3 in both directions.
module code_conv_core
    import code_conv_pkg::*;
(
    input  logic [1:0] mode,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic       err
);

    always_comb begin
        dout = 4'h0;
        err  = 1'b0;
        case (mode)
            MODE_B2G: dout = din ^ (din >> 1);
            MODE_G2B: begin
                dout[3] = din[3];
                dout[2] = ^din[3:2];
                dout[1] = ^din[3:1];
                dout[0] = ^din[3:0];
            end
            MODE_BCD2XS3: begin
                if (din > 4'd9) err = 1'b1;
                else            dout = din + 4'd3;
            end
            MODE_XS32BCD: begin
                if ((din < 4'd3) || (din > 4'd12)) err = 1'b1;
                else                               dout = din - 4'd3;
            end
            default: dout = 4'h0;
        endcase
    end

endmodule

// File: rtl/code_conv_arbiter.sv
// Round-robin arbiter sharing one code_conv_core among NUM_REQ requesters,
// with a three-phase accept / convert / hold-response FSM.
module code_conv_arbiter
    import code_conv_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [2*NUM_REQ-1:0]   req_mode,
    input  logic [4*NUM_REQ-1:0]   req_data,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [3:0]             resp_data,
    output logic                   resp_err,
    output logic [ID_W-1:0]        resp_id,
    output logic                   busy
);

    state_e          state_q, state_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [1:0]      op_mode_q, op_mode_d;
    logic [3:0]      op_data_q, op_data_d;
    logic [ID_W-1:0] op_id_q, op_id_d;
    logic            resp_valid_q, resp_valid_d;
    logic [3:0]      resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic            busy_q, busy_d;

    logic [NUM_REQ-1:0] req_ready_c;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [3:0]         core_dout;
    logic               core_err;

    code_conv_core u_core (
        .mode (op_mode_q),
        .din  (op_data_q),
        .dout (core_dout),
        .err  (core_err)
    );

    // Search upward from the requester after the last one served, wrapping around.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!grant_found && req_valid[ID_W'((32'(last_q) + k) % NUM_REQ)]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'((32'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        op_mode_d    = op_mode_q;
        op_data_d    = op_data_q;
        op_id_d      = op_id_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        resp_id_d    = resp_id_q;
        req_ready_c  = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_found && !rst) begin
                    req_ready_c = NUM_REQ'(1) << grant_idx;
                    op_mode_d   = req_mode[2*grant_idx +: 2];
                    op_data_d   = req_data[4*grant_idx +: 4];
                    op_id_d     = grant_idx;
                    last_d      = grant_idx;
                    state_d     = ST_CONV;
                end
            end
            ST_CONV: begin
                resp_data_d  = core_dout;
                resp_err_d   = core_err;
                resp_id_d    = op_id_q;
                resp_valid_d = 1'b1;
                state_d      = ST_HOLD;
            end
            ST_HOLD: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_q       <= ID_W'(NUM_REQ - 1);
            op_mode_q    <= 2'd0;
            op_data_q    <= 4'h0;
            op_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 4'h0;
            resp_err_q   <= 1'b0;
            resp_id_q    <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            op_mode_q    <= op_mode_d;
            op_data_q    <= op_data_d;
            op_id_q      <= op_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_id_q    <= resp_id_d;
            busy_q       <= busy_d;
        end
    end

    assign req_ready  = req_ready_c;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign resp_id    = resp_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Self-checking bench for code_conv_arbiter: directed scenarios followed by randomized traffic
// compared against a behavioural model of the arbitration and conversion rules.
module tb_code_conv_arbiter;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [2*N-1:0] req_mode;
    logic [4*N-1:0] req_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [3:0]   resp_data;
    logic         resp_err;
    logic [1:0]   resp_id;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int model_last = N - 1;
    int t_resp = 0;

    code_conv_arbiter #(.NUM_REQ(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference conversion: returns {err, data}
    function automatic logic [4:0] ref_conv(input logic [1:0] m, input logic [3:0] d);
        logic [3:0] b;
        logic       acc;
        int         v;
        v = int'(d);
        case (m)
            2'd0: return {1'b0, d ^ {1'b0, d[3:1]}};
            2'd1: begin
                acc = 1'b0;
                for (int i = 3; i >= 0; i--) begin
                    acc  = acc ^ d[i];
                    b[i] = acc;
                end
                return {1'b0, b};
            end
            2'd2: return (v > 9) ? 5'h10 : {1'b0, 4'(v + 3)};
            default: return (v < 3 || v > 12) ? 5'h10 : {1'b0, 4'(v - 3)};
        endcase
    endfunction

    function automatic int exp_grant(input logic [N-1:0] v);
        for (int k = 1; k <= int'(N); k++) begin
            int c;
            c = (model_last + k) % int'(N);
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] m, input logic [3:0] d);
        req_valid[i]      = v;
        req_mode[2*i +: 2] = m;
        req_data[4*i +: 4] = d;
    endtask

    // One full transaction starting in an IDLE cycle; inputs already driven by the caller.
    task automatic txn(input int hold, output int g);
        logic [4:0] e;
        resp_ready = (hold == 0);
        #1;
        g = exp_grant(req_valid);
        chk("req_ready_idle", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
        chk("busy_idle", 32'(busy), 32'd0);
        if (g < 0) begin
            @(posedge clk); #1;
            return;
        end
        e = ref_conv(req_mode[2*g +: 2], req_data[4*g +: 4]);
        model_last = g;
        @(posedge clk); #1;
        chk("busy_conv", 32'(busy), 32'd1);
        chk("resp_valid_conv", 32'(resp_valid), 32'd0);
        chk("req_ready_conv", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        t_resp = cyc;
        chk("resp_valid_hold", 32'(resp_valid), 32'd1);
        chk("resp_data", 32'(resp_data), 32'(e[3:0]));
        chk("resp_err", 32'(resp_err), 32'(e[4]));
        chk("resp_id", 32'(resp_id), 32'(g));
        chk("req_ready_hold", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 4'($urandom);
            @(posedge clk); #1;
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_data", 32'({resp_err, resp_data}), 32'(e));
            chk("hold_id", 32'(resp_id), 32'(g));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("resp_valid_done", 32'(resp_valid), 32'd0);
        chk("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int g;
        int t_prev;

        // Reset with requests pending: nothing may be accepted
        rst = 1'b1;
        resp_ready = 1'b1;
        req_valid = '1;
        req_mode = '0;
        req_data = '0;
        repeat (2) begin
            @(posedge clk); #1;
            chk("req_ready_in_rst", 32'(req_ready), 32'd0);
        end
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", 32'(resp_data), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;

        // Gray-to-binary on requester 0
        set_req(0, 1'b1, 2'd1, 4'b1011);
        txn(0, g);
        req_valid = '0;

        // BCD->XS3 error on requester 2, then XS3->BCD on requester 1
        set_req(2, 1'b1, 2'd2, 4'hA);
        txn(0, g);
        req_valid = '0;
        set_req(1, 1'b1, 2'd3, 4'h7);
        txn(0, g);
        req_valid = '0;

        // Realign priority so all-valid traffic starts at requester 0
        set_req(3, 1'b1, 2'd0, 4'h6);
        txn(0, g);

        // Everyone requesting back-to-back: rotation and a result every 3 cycles
        for (int i = 0; i < int'(N); i++) set_req(i, 1'b1, 2'(i), 4'(i * 3 + 2));
        t_prev = -1;
        for (int n = 0; n < 5; n++) begin
            txn(0, g);
            if (t_prev >= 0) chk("result_spacing", 32'(t_resp - t_prev), 32'd3);
            t_prev = t_resp;
        end

        // Downstream stalls for 5 cycles
        req_valid = '1;
        txn(5, g);

        // Reset while a conversion is in flight
        req_valid = '1;
        #1;
        g = exp_grant(req_valid);
        chk("pre_rst_grant", 32'(req_ready), 32'd1 << g);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        model_last = N - 1;
        txn(0, g);

        // Randomized traffic, including idle cycles and stalls
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < int'(N); i++)
                set_req(i, 1'($urandom_range(0, 2) != 0), 2'($urandom), 4'($urandom));
            txn($urandom_range(0, 3), g);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
